// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one load/store at a time, fixed-latency response pulse.
// Build option: define MISALIGN_TRAP_EN to trap misaligned/unlisted accesses instead of force-aligning.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_d, valid_d, err_d;
    logic [31:0]       rdata_d;
    logic [31:0]       hold_q;
    logic              hold_err_q;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [1:0]        size_c;
    logic              sext_c;
    logic              legal_c;
    logic              fault_c;
    logic [1:0]        off_c;
    logic [ADDR_W-1:0] idx_c;
    logic [3:0]        be_c;
    logic [31:0]       wlane_c;
    logic [31:0]       rword_c;
    logic [31:0]       lane_c;
    logic [31:0]       ext_c;
    logic [31:0]       resp_word_c;
    logic              accept_c;
    logic              unused_addr_c;

    assign unused_addr_c = ^req_addr[31:ADDR_W+2];
    assign idx_c         = req_addr[ADDR_W+1:2];
    assign accept_c      = req_valid && (state_q == ST_IDLE);

    // Decode access size, extension and fault; unlisted encodings fall back to a word access
    always_comb begin
        size_c  = 2'd2;
        sext_c  = 1'b0;
        legal_c = 1'b1;
        case (req_funct3)
            3'b000:  begin size_c = 2'd0; sext_c = 1'b1; end
            3'b001:  begin size_c = 2'd1; sext_c = 1'b1; end
            3'b010:  size_c = 2'd2;
            3'b100:  begin size_c = 2'd0; legal_c = !req_we; end
            3'b101:  begin size_c = 2'd1; legal_c = !req_we; end
            default: legal_c = 1'b0;
        endcase
        if (!legal_c) begin
            size_c = 2'd2;
            sext_c = 1'b0;
        end
        off_c = req_addr[1:0];
`ifdef MISALIGN_TRAP_EN
        fault_c = !legal_c || ((size_c == 2'd1) && req_addr[0])
                           || ((size_c == 2'd2) && (req_addr[1:0] != 2'b00));
`else
        fault_c = 1'b0;
        if (size_c == 2'd1) off_c[0] = 1'b0;
        if (size_c == 2'd2) off_c    = 2'b00;
`endif
    end

    // Store lane replication and byte enables
    always_comb begin
        case (size_c)
            2'd0:    begin be_c = 4'b0001 << off_c; wlane_c = {4{req_wdata[7:0]}};  end
            2'd1:    begin be_c = 4'b0011 << off_c; wlane_c = {2{req_wdata[15:0]}}; end
            default: begin be_c = 4'b1111;          wlane_c = req_wdata;            end
        endcase
    end

    // Load lane select and extension
    always_comb begin
        rword_c = mem[idx_c];
        lane_c  = rword_c >> {off_c, 3'b000};
        case (size_c)
            2'd0:    ext_c = sext_c ? {{24{lane_c[7]}}, lane_c[7:0]}   : {24'h0, lane_c[7:0]};
            2'd1:    ext_c = sext_c ? {{16{lane_c[15]}}, lane_c[15:0]} : {16'h0, lane_c[15:0]};
            default: ext_c = rword_c;
        endcase
        resp_word_c = (req_we || fault_c) ? 32'h0 : ext_c;
    end

    // Array is not reset; stores commit on the accepting edge
    always_ff @(posedge clk) begin
        if (accept_c && req_we && !fault_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) mem[idx_c][8*b +: 8] <= wlane_c[8*b +: 8];
            end
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_RESP);
        rdata_d = resp_rdata;
        err_d   = resp_err;
        if (state_d == ST_RESP) begin
            // Single-cycle latency responds straight from the accepting cycle
            rdata_d = (state_q == ST_IDLE) ? resp_word_c : hold_q;
            err_d   = (state_q == ST_IDLE) ? fault_c     : hold_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            hold_q     <= '0;
            hold_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_ready  <= ready_d;
            resp_valid <= valid_d;
            resp_rdata <= rdata_d;
            resp_err   <= err_d;
            if (accept_c) begin
                hold_q     <= resp_word_c;
                hold_err_q <= fault_c;
            end
        end
    end

endmodule
